// File: rtl/arb_rr_n.sv
// arb_rr_n: N-way round-robin arbiter with bounded grant hold.
//   One requester owns the grant at a time. The owner keeps the grant while it
//   holds req, for at most MAX_HOLD consecutive cycles (0 = no limit). After
//   that, the grant rotates. The scan starts one past the last owner, so the
//   previous owner is always scanned last.
// Ports:
//   clk      single clock, all state updates on posedge
//   rst      synchronous active-high reset
//   req      [N-1:0] level-sensitive request vector
//   gnt      [N-1:0] registered one-hot grant, zero when there is no owner
//   gnt_vld  registered, high when gnt is non-zero
//   gnt_idx  [IDX_W-1:0] registered binary index of the owner, 0 when idle
module arb_rr_n #(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 4,
   localparam int IDX_W    = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic             gnt_vld,
   output logic [IDX_W-1:0] gnt_idx
);

   localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam bit UNLIM = (MAX_HOLD == 0);

   logic [N-1:0]     r_gnt;
   logic             r_vld;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_ptr;
   logic [HCW-1:0]   r_hold;

   logic             w_keep;
   logic             w_found;
   logic [IDX_W-1:0] w_pick;

   // Modulo-N wrap for values in 0..2N-2, so non-power-of-2 N never produces
   // an index >= N.
   function automatic logic [IDX_W-1:0] f_wrap(input int v);
      int t;
      t = (v >= N) ? v - N : v;
      return IDX_W'(t);
   endfunction

   // The first requester found at or after r_ptr, in rotation order.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && req[f_wrap(int'(r_ptr) + k)]) begin
            w_found = 1'b1;
            w_pick  = f_wrap(int'(r_ptr) + k);
         end
      end
   end

   // r_hold counts cycles already spent in this tenure minus one. The tenure
   // may extend only while that count is below MAX_HOLD-1.
   assign w_keep = r_vld && req[r_idx] && (UNLIM || (r_hold < HOLD_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt  <= '0;
         r_vld  <= 1'b0;
         r_idx  <= '0;
         r_ptr  <= '0;
         r_hold <= '0;
      end else if (w_keep) begin
         // In unlimited mode the counter has no effect, so it only saturates.
         if (!UNLIM || (r_hold != '1)) begin
            r_hold <= r_hold + HCW'(1);
         end
      end else if (w_found) begin
         r_gnt  <= N'(1) << w_pick;
         r_vld  <= 1'b1;
         r_idx  <= w_pick;
         r_ptr  <= f_wrap(int'(w_pick) + 1);
         r_hold <= '0;
      end else begin
         r_gnt <= '0;
         r_vld <= 1'b0;
         r_idx <= '0;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_vld = r_vld;
   assign gnt_idx = r_idx;

endmodule

// File: tb/tb_arb_rr_n.sv
// tb_arb_rr_n: four arbiters with N=4 run side by side on the same request
// stream. They use MAX_HOLD = 4, 1, 0 and 2. A tenure-level reference model
// predicts every grant. The driver queues each prediction, and a monitor
// compares the outputs after every clock edge.
module tb_arb_rr_n;

   localparam int ND = 4;
   localparam int MH [ND] = '{4, 1, 0, 2};

   typedef struct packed {
      logic [ND-1:0][3:0] g;
      logic [ND-1:0]      v;
      logic [ND-1:0][1:0] x;
   } exp_t;

   logic clk;
   logic rst;
   logic [3:0] req;
   logic [ND-1:0][3:0] gnt_a;
   logic [ND-1:0]      vld_a;
   logic [ND-1:0][1:0] idx_a;

   exp_t exp_q[$];
   exp_t e_mon;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: -1 means no owner. m_ten counts cycles granted so far
   // in the current tenure.
   int m_own [ND];
   int m_ten [ND];
   int m_ptr [ND];

   arb_rr_n #(.N(4), .MAX_HOLD(4)) u_d0 (.clk(clk), .rst(rst), .req(req),
      .gnt(gnt_a[0]), .gnt_vld(vld_a[0]), .gnt_idx(idx_a[0]));
   arb_rr_n #(.N(4), .MAX_HOLD(1)) u_d1 (.clk(clk), .rst(rst), .req(req),
      .gnt(gnt_a[1]), .gnt_vld(vld_a[1]), .gnt_idx(idx_a[1]));
   arb_rr_n #(.N(4), .MAX_HOLD(0)) u_d2 (.clk(clk), .rst(rst), .req(req),
      .gnt(gnt_a[2]), .gnt_vld(vld_a[2]), .gnt_idx(idx_a[2]));
   arb_rr_n #(.N(4), .MAX_HOLD(2)) u_d3 (.clk(clk), .rst(rst), .req(req),
      .gnt(gnt_a[3]), .gnt_vld(vld_a[3]), .gnt_idx(idx_a[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int d, input int act, input int exp_v);
      n_checks++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s dut%0d (MAX_HOLD=%0d) actual=%0d expected=%0d at %0t",
                    nm, d, MH[d], act, exp_v, $time);
   endtask

   // Drive one cycle of stimulus and queue the predicted outputs after the edge.
   task automatic step(input logic [3:0] r, input logic rs);
      exp_t e;
      bit found;
      @(negedge clk);
      req = r;
      rst = rs;
      for (int d = 0; d < ND; d++) begin
         if (rs) begin
            m_own[d] = -1; m_ten[d] = 0; m_ptr[d] = 0;
         end else if (m_own[d] >= 0 && r[m_own[d]] && (MH[d] == 0 || m_ten[d] < MH[d])) begin
            m_ten[d]++;
         end else begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
               int i;
               i = (m_ptr[d] + k) % 4;
               if (!found && r[i]) begin
                  found = 1; m_own[d] = i; m_ten[d] = 1; m_ptr[d] = (i + 1) % 4;
               end
            end
            if (!found) m_own[d] = -1;
         end
         e.g[d] = (m_own[d] >= 0) ? 4'(1 << m_own[d]) : 4'b0000;
         e.v[d] = (m_own[d] >= 0);
         e.x[d] = (m_own[d] >= 0) ? 2'(m_own[d]) : 2'd0;
      end
      exp_q.push_back(e);
   endtask

   task automatic run(input logic [3:0] r, input int cycles);
      for (int c = 0; c < cycles; c++) step(r, 1'b0);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         e_mon = exp_q.pop_front();
         for (int d = 0; d < ND; d++) begin
            chk("gnt",     d, int'(gnt_a[d]), int'(e_mon.g[d]));
            chk("gnt_vld", d, int'(vld_a[d]), int'(e_mon.v[d]));
            chk("gnt_idx", d, int'(idx_a[d]), int'(e_mon.x[d]));
         end
      end
   end

   initial begin
      logic [3:0] r;
      logic rs;
      rst = 1'b1;
      req = 4'b0000;
      for (int d = 0; d < ND; d++) begin
         m_own[d] = -1; m_ten[d] = 0; m_ptr[d] = 0;
      end

      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      // Reset while requester 2 owns the grant, then check that ptr restarts at 0.
      run(4'b0100, 2);
      step(4'b0100, 1'b1);
      run(4'b1111, 14);
      // Owner 0 with req=0101, then release requester 0.
      step(4'b0000, 1'b1);
      run(4'b0101, 3);
      run(4'b0100, 3);
      // A single requester across hold expiry.
      run(4'b0010, 10);
      // Alternating pair, then all requests drop.
      step(4'b0000, 1'b1);
      run(4'b1010, 6);
      run(4'b0000, 2);

      r = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         rs = ($urandom_range(0, 59) == 0);
         step(r, rs);
      end
      run(4'b0000, 2);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("drain", 0, exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
